blind_position_emulator: RTL and testbench
==========================================

// Module: blind_position_emulator
// PURPOSE
//  Plant model for the automatic blind: the receiving end of the controller's motor
//  commands (subir/bajar). It integrates travel into a blind position and produces
//  the limit/mid sensors (sinf/smed/ssup) the blind FSM consumes.
//  Used in closed-loop sim and on-board demo in place of the ui_in[7:5] switches.
// PARAMETERS
//  STEP_DIV      1000000  clk cycles per position step while moving (>=2)
//  POS_MAX       100      fully-open position; pos range 0..POS_MAX (<=255)
//  MID_POS       50       centre of mid sensor (0 < MID_POS < POS_MAX)
//  MID_WIN       2        smed asserted when |pos-MID_POS| <= MID_WIN
//  POS_INIT      0        position loaded at reset (0 = closed)
//  OVERRUN_STEPS 3        blocked steps against a limit before stall fault (>=1)
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  reset, asynchronous, active-low
//  subir       in   1  motor up command
//  bajar       in   1  motor down command
//  clear_fault in   1  leaves FAULT when subir=bajar=0
//  pos         out  8  current blind position
//  sinf        out  1  lower limit sensor (pos==0)
//  smed        out  1  mid sensor
//  ssup        out  1  upper limit sensor (pos==POS_MAX)
//  moving      out  1  1 in UP/DOWN
//  fault       out  1  1 in FAULT
// BEHAVIOUR
//  Reset (async): state=IDLE, pos=POS_INIT, prescaler=0, overrun=0, fault=0,
//   moving=0; sensors take values decoded from POS_INIT immediately.
//  FSM (registered): IDLE, UP, DOWN, FAULT.
//   IDLE: subir&bajar->FAULT; subir->UP; bajar->DOWN; else stay.
//   UP:   subir&bajar->FAULT; !subir&bajar->IDLE; !subir&!bajar->IDLE; else stay.
//   DOWN: mirror of UP.
//   FAULT: stay until clear_fault & !subir & !bajar -> IDLE.
//   Reversal always passes through IDLE for exactly one cycle.
//  Prescaler: cleared in IDLE/FAULT and on entry to UP/DOWN; counts 0..STEP_DIV-1
//   in UP/DOWN; step pulse when count==STEP_DIV-1 (wraps to 0). First step lands on
//   the STEP_DIV-th edge after the edge that entered UP/DOWN.
//  Step in UP: pos<POS_MAX -> pos+1, overrun=0; pos==POS_MAX -> pos held, overrun+1.
//   DOWN symmetric at 0. pos never wraps below 0 or above POS_MAX.
//  overrun cleared on leaving UP/DOWN; overrun reaching OVERRUN_STEPS -> FAULT on
//   that same edge.
//  FAULT: pos frozen, moving=0, fault=1; sensors keep reflecting pos.
//  Sensors registered from pos: valid one cycle after pos updates.
//  clear_fault ignored outside FAULT. No other inputs are synchronised here.
// TESTING (STEP_DIV=4, POS_MAX=10, MID_POS=5, MID_WIN=0, POS_INIT=0, OVERRUN_STEPS=3)
//  1 Reset release -> pos=0, sinf=1, smed=0, ssup=0, moving=0, fault=0.
//  2 subir held 40 cycles -> pos+1 every 4 cycles, first at cycle 4; smed=1 only
//    while pos==5 (1-cycle lag); pos=10 at cycle 40, ssup=1 next cycle, sinf=0.
//  3 Keep subir at top 12 more cycles -> 3 blocked steps, fault=1, moving=0, pos=10.
//  4 From IDLE assert subir&bajar same cycle -> fault=1 next edge; clear_fault while
//    subir=1 -> stays FAULT; clear_fault with both low -> IDLE, fault=0.
//  5 At pos=6 in UP switch to bajar -> 1 IDLE cycle, then pos=5 four cycles later.
//  6 rst_n low mid-travel (pos=7) -> pos=0, sinf=1, state IDLE without waiting for clk.

Source files
------------

// File: rtl/blind_position_emulator.sv
// Plant model of the motorised blind: integrates subir/bajar travel into a position
// and produces the registered limit/mid sensors plus a stall/conflict fault.
module blind_position_emulator #(
   parameter int STEP_DIV      = 1000000,
   parameter int POS_MAX       = 100,
   parameter int MID_POS       = 50,
   parameter int MID_WIN       = 2,
   parameter int POS_INIT      = 0,
   parameter int OVERRUN_STEPS = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       subir,
   input  logic       bajar,
   input  logic       clear_fault,
   output logic [7:0] pos,
   output logic       sinf,
   output logic       smed,
   output logic       ssup,
   output logic       moving,
   output logic       fault
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_UP    = 2'd1;
   localparam logic [1:0] ST_DOWN  = 2'd2;
   localparam logic [1:0] ST_FAULT = 2'd3;

   localparam logic [31:0] STEP_LAST  = 32'(STEP_DIV - 1);
   localparam logic [7:0]  POS_MAX_C  = 8'(POS_MAX);
   localparam logic [7:0]  POS_INIT_C = 8'(POS_INIT);
   localparam logic [7:0]  OVR_LAST   = 8'(OVERRUN_STEPS - 1);

   logic [1:0]  state_q, state_d;
   logic [7:0]  pos_q, pos_d;
   logic [31:0] presc_q, presc_d;
   logic [7:0]  ovr_q, ovr_d;
   logic        sinf_q, smed_q, ssup_q, moving_q, fault_q;

   function automatic logic mid_hit(input logic [7:0] p);
      int d;
      d = int'(p) - MID_POS;
      if (d < 0) begin
         d = -d;
      end else begin
         d = d;
      end
      return (d <= MID_WIN);
   endfunction

   // Next-state, prescaler and position integration
   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      presc_d = presc_q;
      ovr_d   = ovr_q;
      case (state_q)
         ST_IDLE: begin
            presc_d = 32'd0;
            ovr_d   = 8'd0;
            if (subir && bajar) begin
               state_d = ST_FAULT;
            end else if (subir) begin
               state_d = ST_UP;
            end else if (bajar) begin
               state_d = ST_DOWN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_UP, ST_DOWN: begin
            if (subir && bajar) begin
               state_d = ST_FAULT;
               presc_d = 32'd0;
               ovr_d   = 8'd0;
            end else if ((state_q == ST_UP) ? !subir : !bajar) begin
               state_d = ST_IDLE;
               presc_d = 32'd0;
               ovr_d   = 8'd0;
            end else if (presc_q == STEP_LAST) begin
               presc_d = 32'd0;
               if ((state_q == ST_UP) && (pos_q < POS_MAX_C)) begin
                  pos_d = pos_q + 8'd1;
                  ovr_d = 8'd0;
               end else if ((state_q == ST_DOWN) && (pos_q != 8'd0)) begin
                  pos_d = pos_q - 8'd1;
                  ovr_d = 8'd0;
               end else if (ovr_q == OVR_LAST) begin
                  // blocked at a limit long enough: motor considered stalled
                  state_d = ST_FAULT;
                  ovr_d   = 8'd0;
               end else begin
                  ovr_d = ovr_q + 8'd1;
               end
            end else begin
               presc_d = presc_q + 32'd1;
            end
         end
         ST_FAULT: begin
            presc_d = 32'd0;
            ovr_d   = 8'd0;
            if (clear_fault && !subir && !bajar) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_FAULT;
            end
         end
         default: begin
            state_d = ST_IDLE;
            presc_d = 32'd0;
            ovr_d   = 8'd0;
         end
      endcase
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         pos_q    <= POS_INIT_C;
         presc_q  <= 32'd0;
         ovr_q    <= 8'd0;
         sinf_q   <= (POS_INIT_C == 8'd0);
         smed_q   <= mid_hit(POS_INIT_C);
         ssup_q   <= (POS_INIT_C == POS_MAX_C);
         moving_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         presc_q  <= presc_d;
         ovr_q    <= ovr_d;
         sinf_q   <= (pos_q == 8'd0);
         smed_q   <= mid_hit(pos_q);
         ssup_q   <= (pos_q == POS_MAX_C);
         moving_q <= (state_d == ST_UP) || (state_d == ST_DOWN);
         fault_q  <= (state_d == ST_FAULT);
      end
   end

   assign pos    = pos_q;
   assign sinf   = sinf_q;
   assign smed   = smed_q;
   assign ssup   = ssup_q;
   assign moving = moving_q;
   assign fault  = fault_q;

endmodule

// File: tb/tb_blind_position_emulator.sv
// Directed bench for blind_position_emulator: stimulus pushes expected outputs into
// a queue, a monitor pops and compares one entry after every clock edge.
module tb_blind_position_emulator;

   typedef struct {
      string      name;
      logic [7:0] pos;
      logic       sinf, smed, ssup, moving, fault;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       subir = 1'b0, bajar = 1'b0, clear_fault = 1'b0;
   logic [7:0] pos;
   logic       sinf, smed, ssup, moving, fault;

   int   tests = 0;
   int   fails = 0;
   exp_t q[$];
   int   prev_pos = 0;

   blind_position_emulator #(
      .STEP_DIV(4), .POS_MAX(10), .MID_POS(5), .MID_WIN(0),
      .POS_INIT(0), .OVERRUN_STEPS(3)
   ) dut (
      .clk(clk), .rst_n(rst_n), .subir(subir), .bajar(bajar),
      .clear_fault(clear_fault), .pos(pos), .sinf(sinf), .smed(smed),
      .ssup(ssup), .moving(moving), .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic compare(input exp_t e);
      tests++;
      if (pos !== e.pos || sinf !== e.sinf || smed !== e.smed || ssup !== e.ssup ||
          moving !== e.moving || fault !== e.fault) begin
         fails++;
         $display("FAIL %s: got pos=%0d sinf=%b smed=%b ssup=%b mov=%b flt=%b, want pos=%0d sinf=%b smed=%b ssup=%b mov=%b flt=%b",
                  e.name, pos, sinf, smed, ssup, moving, fault,
                  e.pos, e.sinf, e.smed, e.ssup, e.moving, e.fault);
      end
   endtask

   // Monitor: one expected entry is consumed after each rising edge
   always @(posedge clk) begin
      #1;
      if (q.size() > 0) compare(q.pop_front());
   end

   // One clock of stimulus; sensors lag the expected position by one cycle
   task automatic cyc(input logic s, input logic b, input logic c, input string nm,
                      input int p, input logic mv, input logic fl);
      exp_t e;
      @(negedge clk);
      subir = s; bajar = b; clear_fault = c;
      e.name = nm; e.pos = 8'(p); e.moving = mv; e.fault = fl;
      e.sinf = (prev_pos == 0); e.smed = (prev_pos == 5); e.ssup = (prev_pos == 10);
      q.push_back(e);
      prev_pos = p;
   endtask

   task automatic direct(input string nm, input int p);
      exp_t e;
      e.name = nm; e.pos = 8'(p); e.moving = 1'b0; e.fault = 1'b0;
      e.sinf = (p == 0); e.smed = (p == 5); e.ssup = (p == 10);
      compare(e);
   endtask

   initial begin
      int p;
      #23;
      direct("reset_held", 0);
      @(negedge clk); rst_n = 1'b1;
      direct("reset_release", 0);
      prev_pos = 0;

      // Climb to the top, then stall against it
      for (int k = 0; k <= 52; k++) begin
         p = (k / 4 > 10) ? 10 : k / 4;
         cyc(1'b1, 1'b0, 1'b0, (k <= 40) ? "up_travel" : "up_overrun", p,
             (k < 52), (k == 52));
      end
      cyc(1'b1, 1'b0, 1'b0, "fault_hold", 10, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b1, "fault_clr_subir", 10, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, "fault_clear", 10, 1'b0, 1'b0);

      // Conflicting commands from IDLE
      cyc(1'b1, 1'b1, 1'b0, "both_fault", 10, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b1, "clr_ignored", 10, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, "clr_both_low", 10, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, "clr_in_idle", 10, 1'b0, 1'b0);

      // Down to 6, stop
      for (int k = 0; k <= 16; k++) begin
         cyc(1'b0, 1'b1, 1'b0, "down_to6", 10 - k / 4, 1'b1, 1'b0);
      end
      cyc(1'b0, 1'b0, 1'b0, "stop_idle", 6, 1'b0, 1'b0);

      // Reversal at pos 6: UP, then bajar forces one IDLE cycle before DOWN
      for (int k = 0; k <= 2; k++) begin
         cyc(1'b1, 1'b0, 1'b0, "up_at6", 6, 1'b1, 1'b0);
      end
      cyc(1'b0, 1'b1, 1'b0, "reverse_idle", 6, 1'b0, 1'b0);
      for (int k = 0; k <= 36; k++) begin
         p = (6 - k / 4 < 0) ? 0 : 6 - k / 4;
         cyc(1'b0, 1'b1, 1'b0, (k <= 24) ? "down_travel" : "down_overrun", p,
             (k < 36), (k == 36));
      end
      cyc(1'b0, 1'b0, 1'b1, "clear_bottom", 0, 1'b0, 0);

      // Climb to 7, then assert reset between edges
      for (int k = 0; k <= 28; k++) begin
         cyc(1'b1, 1'b0, 1'b0, "up_to7", k / 4, 1'b1, 1'b0);
      end
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      direct("async_reset", 0);
      subir = 1'b0;
      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
      #2;
      if (q.size() != 0) begin
         tests++; fails++;
         $display("FAIL drain: got %0d entries left, want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
